csm_datapath: RTL and testbench

Datapath core of the uCode stack machine: a registered 16-bit ALU, a push/pop return stack (R) and a data stack (D) with stack-effect commands. It sits under the uCode sequencer, which selects ALU operands and issues stack commands. Operands are `d0`/`d1`/`r0`, constants are chosen outside, and ALU results are written back to the stacks on the following cycle. All three sub-units share one clock and one reset and have no handshake.

---
 rtl/csm_datapath.sv | 140 ++++++++++++++
 tb/tb_csm_datapath.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/csm_datapath.sv
// Datapath core of the uCode stack machine: registered ALU, return stack (R)
// and data stack (D) with stack-effect commands, all on one clock.
module csm_datapath #(
  parameter int WIDTH   = 16,
  parameter int D_DEPTH = 12,
  parameter int R_DEPTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_alu_op,
  input  logic [WIDTH-1:0] i_alu_arg0,
  input  logic [WIDTH-1:0] i_alu_arg1,
  output logic [WIDTH-1:0] o_alu_data,
  input  logic [WIDTH-1:0] i_r_data,
  input  logic             i_r_push,
  input  logic             i_r_pop,
  output logic [WIDTH-1:0] o_r0,
  output logic [WIDTH-1:0] o_r1,
  input  logic [WIDTH-1:0] i_d_data,
  input  logic [2:0]       i_d_se,
  output logic [WIDTH-1:0] o_d0,
  output logic [WIDTH-1:0] o_d1
);

  typedef enum logic [2:0] {
    SE_NONE = 3'd0,
    SE_DROP = 3'd1,
    SE_PUSH = 3'd2,
    SE_RPLC = 3'd3,
    SE_SWAP = 3'd4,
    SE_ROT  = 3'd5,
    SE_RROT = 3'd6,
    SE_ALU2 = 3'd7
  } d_se_e;

  function automatic logic [WIDTH-1:0] alu_f(input logic [3:0]       op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0]   sa;
    logic signed [WIDTH-1:0]   sb;
    logic        [2*WIDTH-1:0] prod;
    logic        [WIDTH-1:0]   r;
    sa   = a;
    sb   = b;
    prod = a * b;
    r    = a;
    case (op)
      4'h0:    r = a;
      4'h1:    r = a + b;
      4'h2:    r = a - b;
      4'h3:    r = prod[WIDTH-1:0];
      4'h4:    r = a & b;
      4'h5:    r = a ^ b;
      4'h6:    r = a | b;
      4'h7:    r = {a[WIDTH-2:0], a[WIDTH-1]};
      4'h8:    r = {a[0], a[WIDTH-1:1]};
      4'h9:    r = a << b[3:0];
      4'hA:    r = a >> b[3:0];
      4'hB:    r = sa >>> b[3:0];
      4'hC:    r = {WIDTH{a == b}};
      4'hD:    r = {WIDTH{sa < sb}};
      4'hE:    r = {WIDTH{a < b}};
      default: r = a;  // MEM: sequencer bypasses the ALU
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] alu_data_p1;
  logic [WIDTH-1:0] r_q [R_DEPTH];
  logic [WIDTH-1:0] d_q [D_DEPTH];

  // ALU stage p0 -> p1
  always_ff @(posedge i_clk) begin
    if (i_rst) alu_data_p1 <= '0;
    else       alu_data_p1 <= alu_f(i_alu_op, i_alu_arg0, i_alu_arg1);
  end

  assign o_alu_data = alu_data_p1;

  // R stack: push+pop on the same edge is a top replace, no depth change
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < R_DEPTH; i++) r_q[i] <= '0;
    end else if (i_r_push && i_r_pop) begin
      r_q[0] <= i_r_data;
    end else if (i_r_push) begin
      r_q[0] <= i_r_data;
      for (int i = 1; i < R_DEPTH; i++) r_q[i] <= r_q[i-1];
    end else if (i_r_pop) begin
      for (int i = 0; i < R_DEPTH-1; i++) r_q[i] <= r_q[i+1];
      r_q[R_DEPTH-1] <= '0;
    end
  end

  assign o_r0 = r_q[0];
  assign o_r1 = r_q[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < D_DEPTH; i++) d_q[i] <= '0;
    end else begin
      case (i_d_se)
        SE_DROP: begin
          for (int i = 0; i < D_DEPTH-1; i++) d_q[i] <= d_q[i+1];
          d_q[D_DEPTH-1] <= '0;
        end
        SE_PUSH: begin
          d_q[0] <= i_d_data;
          for (int i = 1; i < D_DEPTH; i++) d_q[i] <= d_q[i-1];
        end
        SE_RPLC: d_q[0] <= i_d_data;
        SE_SWAP: begin
          d_q[0] <= d_q[1];
          d_q[1] <= d_q[0];
        end
        SE_ROT: begin
          d_q[0] <= d_q[2];
          d_q[1] <= d_q[0];
          d_q[2] <= d_q[1];
        end
        SE_RROT: begin
          d_q[0] <= d_q[1];
          d_q[1] <= d_q[2];
          d_q[2] <= d_q[0];
        end
        SE_ALU2: begin
          // two operands consumed, one result pushed: net shift up by one
          d_q[0] <= i_d_data;
          for (int i = 1; i < D_DEPTH-1; i++) d_q[i] <= d_q[i+1];
          d_q[D_DEPTH-1] <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_d0 = d_q[0];
  assign o_d1 = d_q[1];

endmodule

// File: tb/tb_csm_datapath.sv
// Self-checking bench for csm_datapath: vector tables for ALU and stacks,
// scoreboard queue for the one-cycle ALU latency, plus reset/overflow sequences.
module tb_csm_datapath;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_arg0, alu_arg1, alu_data;
  logic [W-1:0] r_data, r0, r1;
  logic         r_push, r_pop;
  logic [W-1:0] d_data, d0, d1;
  logic [2:0]   d_se;

  always #5 clk = ~clk;

  csm_datapath #(.WIDTH(W), .D_DEPTH(12), .R_DEPTH(12)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_op(alu_op), .i_alu_arg0(alu_arg0), .i_alu_arg1(alu_arg1),
    .o_alu_data(alu_data),
    .i_r_data(r_data), .i_r_push(r_push), .i_r_pop(r_pop),
    .o_r0(r0), .o_r1(r1),
    .i_d_data(d_data), .i_d_se(d_se),
    .o_d0(d0), .o_d1(d1)
  );

  typedef struct { logic [3:0] op; logic [W-1:0] a, b, e; string nm; } alu_vec_t;
  typedef struct { logic [2:0] se; logic [W-1:0] data, e0, e1; string nm; } d_vec_t;
  typedef struct { logic push, pop; logic [W-1:0] data, e0, e1; string nm; } r_vec_t;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb_q[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu"}, alu_data, '0);
    chk({tag, "_d0"}, d0, '0);
    chk({tag, "_d1"}, d1, '0);
    chk({tag, "_r0"}, r0, '0);
    chk({tag, "_r1"}, r1, '0);
  endtask

  alu_vec_t av[$];
  d_vec_t   dv[$];
  r_vec_t   rv[$];

  initial begin
    logic [W-1:0] prev, e;

    av.push_back('{4'h0, 16'h8001, 16'h0003, 16'h8001, "NOP"});
    av.push_back('{4'h1, 16'h8001, 16'h0003, 16'h8004, "ADD"});
    av.push_back('{4'h2, 16'h8001, 16'h0003, 16'h7FFE, "SUB"});
    av.push_back('{4'h3, 16'h8001, 16'h0003, 16'h8003, "MUL"});
    av.push_back('{4'h4, 16'h8001, 16'h0003, 16'h0001, "AND"});
    av.push_back('{4'h5, 16'h8001, 16'h0003, 16'h8002, "XOR"});
    av.push_back('{4'h6, 16'h8001, 16'h0003, 16'h8003, "OR"});
    av.push_back('{4'h7, 16'h8001, 16'h0003, 16'h0003, "ROL"});
    av.push_back('{4'h8, 16'h8001, 16'h0003, 16'hC000, "ROR"});
    av.push_back('{4'h9, 16'h8001, 16'h0003, 16'h0008, "LSL"});
    av.push_back('{4'hA, 16'h8001, 16'h0003, 16'h1000, "LSR"});
    av.push_back('{4'hB, 16'h8001, 16'h0003, 16'hF000, "ASR"});
    av.push_back('{4'hC, 16'h8001, 16'h0003, 16'h0000, "EQ"});
    av.push_back('{4'hD, 16'h8001, 16'h0003, 16'hFFFF, "LT"});
    av.push_back('{4'hE, 16'h8001, 16'h0003, 16'h0000, "ULT"});
    av.push_back('{4'hF, 16'h1234, 16'h0003, 16'h1234, "MEM"});
    av.push_back('{4'h1, 16'hFFFF, 16'h0001, 16'h0000, "ADD_wrap"});
    av.push_back('{4'h3, 16'h1234, 16'h0100, 16'h3400, "MUL_trunc"});
    av.push_back('{4'hC, 16'h5A5A, 16'h5A5A, 16'hFFFF, "EQ_true"});
    av.push_back('{4'h9, 16'h0001, 16'h0013, 16'h0008, "LSL_b3_0"});
    av.push_back('{4'hB, 16'h4000, 16'h0002, 16'h1000, "ASR_pos"});
    av.push_back('{4'hE, 16'h0003, 16'h8001, 16'hFFFF, "ULT_true"});

    dv.push_back('{3'd2, 16'd1, 16'd1, 16'd0, "PUSH1"});
    dv.push_back('{3'd2, 16'd2, 16'd2, 16'd1, "PUSH2"});
    dv.push_back('{3'd2, 16'd3, 16'd3, 16'd2, "PUSH3"});
    dv.push_back('{3'd0, 16'd7, 16'd3, 16'd2, "NONE"});
    dv.push_back('{3'd5, 16'd0, 16'd1, 16'd3, "ROT"});
    dv.push_back('{3'd6, 16'd0, 16'd3, 16'd2, "RROT"});
    dv.push_back('{3'd4, 16'd0, 16'd2, 16'd3, "SWAP"});
    dv.push_back('{3'd7, 16'd9, 16'd9, 16'd1, "ALU2"});
    dv.push_back('{3'd3, 16'd5, 16'd5, 16'd1, "RPLC"});
    dv.push_back('{3'd1, 16'd0, 16'd1, 16'd0, "DROP1"});
    dv.push_back('{3'd1, 16'd0, 16'd0, 16'd0, "DROP2"});

    rv.push_back('{1'b1, 1'b0, 16'h000A, 16'h000A, 16'h0000, "RPUSH_A"});
    rv.push_back('{1'b1, 1'b0, 16'h000B, 16'h000B, 16'h000A, "RPUSH_B"});
    rv.push_back('{1'b0, 1'b0, 16'h00FF, 16'h000B, 16'h000A, "RHOLD"});
    rv.push_back('{1'b1, 1'b1, 16'h000C, 16'h000C, 16'h000A, "RREPL_C"});
    rv.push_back('{1'b0, 1'b1, 16'h0000, 16'h000A, 16'h0000, "RPOP1"});
    rv.push_back('{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, "RPOP_EMPTY"});

    rst = 1'b1; alu_op = 4'h0; alu_arg0 = '0; alu_arg1 = '0;
    r_data = '0; r_push = 1'b0; r_pop = 1'b0; d_data = '0; d_se = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    chk_all_zero("reset");

    // ALU: result must not move before the edge, and must appear right after it
    prev = '0;
    foreach (av[i]) begin
      alu_op = av[i].op; alu_arg0 = av[i].a; alu_arg1 = av[i].b;
      sb_q.push_back(av[i].e);
      #1;
      chk({av[i].nm, "_hold"}, alu_data, prev);
      tick();
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s: got empty scoreboard expected entry", av[i].nm);
      end else begin
        e = sb_q.pop_front();
        chk(av[i].nm, alu_data, e);
        prev = e;
      end
    end
    alu_op = 4'h0; alu_arg0 = '0; alu_arg1 = '0;

    foreach (dv[i]) begin
      d_se = dv[i].se; d_data = dv[i].data;
      tick();
      chk({dv[i].nm, "_d0"}, d0, dv[i].e0);
      chk({dv[i].nm, "_d1"}, d1, dv[i].e1);
    end
    d_se = 3'd0;

    // overflow: 13 pushes into 12 cells loses value 1
    for (int k = 1; k <= 13; k++) begin
      d_se = 3'd2; d_data = W'(k);
      tick();
    end
    chk("ovf_top_d0", d0, 16'd13);
    chk("ovf_top_d1", d1, 16'd12);
    d_se = 3'd1;
    for (int k = 0; k < 11; k++) tick();
    chk("ovf_last_d0", d0, 16'd2);
    chk("ovf_last_d1", d1, 16'd0);
    tick();
    chk("ovf_under_d0", d0, 16'd0);
    tick();
    chk("ovf_under2_d0", d0, 16'd0);
    d_se = 3'd0;

    foreach (rv[i]) begin
      r_push = rv[i].push; r_pop = rv[i].pop; r_data = rv[i].data;
      tick();
      chk({rv[i].nm, "_r0"}, r0, rv[i].e0);
      chk({rv[i].nm, "_r1"}, r1, rv[i].e1);
    end
    r_push = 1'b0; r_pop = 1'b0;

    // load state everywhere, then reset coincident with push commands
    d_se = 3'd2; d_data = 16'h1111; r_push = 1'b1; r_data = 16'h2222;
    alu_op = 4'h1; alu_arg0 = 16'h0100; alu_arg1 = 16'h0001;
    tick();
    tick();
    chk("pre_rst_alu", alu_data, 16'h0101);
    chk("pre_rst_d1", d1, 16'h1111);
    chk("pre_rst_r1", r1, 16'h2222);
    rst = 1'b1;
    tick();
    chk_all_zero("rst_vs_push");
    rst = 1'b0; d_se = 3'd0; r_push = 1'b0; alu_op = 4'h0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
